serial_paralelo_rx: RTL and testbench
=====================================

SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC: alignment/comma symbol.
REQ-002 SHALL have parameter N_LOCK, default 4, range 2..15: consecutive aligned commas required to go active.
REQ-003 SHALL have port clk_32f, input, 1: serial bit clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port data_in, input, 1: serial bit stream, MSB of each byte first.
REQ-006 SHALL have port data_out, output, 8: last received data byte.
REQ-007 SHALL have port valid_out, output, 1: one-cycle strobe marking a new byte on data_out.
REQ-008 SHALL have port active, output, 1: link aligned and delivering data.

Function
REQ-009 SHALL shift data_in into an 8-bit register each edge: nxt = {shift[6:0], data_in}.
REQ-010 SHALL implement states UNLOCKED, ALIGNING, ACTIVE plus a 3-bit bit counter and a comma counter sized for N_LOCK.
REQ-011 SHALL, in UNLOCKED, compare nxt with COMMA every edge; on match go to ALIGNING, comma count 1, bit counter 0.
REQ-012 SHALL, in ALIGNING, evaluate nxt only at byte boundaries (bit counter == 7); COMMA increments comma count, any other byte returns to UNLOCKED with comma count 0.
REQ-013 SHALL enter ACTIVE and assert active at the boundary edge where the N_LOCK-th consecutive comma completes.
REQ-014 SHALL, in ACTIVE, at each boundary edge register data_out <= nxt and pulse valid_out high for exactly one cycle if nxt != COMMA.
REQ-015 SHALL, for a COMMA byte in ACTIVE, keep valid_out low and data_out unchanged (default build).
REQ-016 SHALL give latency 0 cycles from the edge sampling a byte's last bit to the registered data_out/valid_out update; valid_out pulses are 8 cycles apart minimum.
REQ-017 SHALL keep bit counter free-running modulo 8 once aligned; it wraps 7 -> 0 without gaps.
REQ-018 SHALL remain in ACTIVE until reset; no loss-of-sync detection.
REQ-019 SHALL never assert valid_out outside ACTIVE.

Reset
REQ-020 SHALL, while reset = 0, force shift=0, bit counter=0, comma count=0, state=UNLOCKED, data_out=8'h00, valid_out=0, active=0, immediately (asynchronous).
REQ-021 SHALL, on reset asserted mid-byte or mid-alignment, discard all partial state; alignment restarts from UNLOCKED after release.
REQ-022 SHALL begin sampling data_in on the first rising edge after reset rises.

Configuration
REQ-023 SHALL support macro RX_COMMA_PASS_EN.
REQ-024 SHALL, with RX_COMMA_PASS_EN defined, treat COMMA bytes in ACTIVE like data: data_out <= COMMA, valid_out pulses.
REQ-025 SHALL, without RX_COMMA_PASS_EN, filter commas per REQ-015.

Structure
REQ-026 SHALL place COMMA default (8'hBC), N_LOCK default, and the state enum typedef in shared package phy_pkg.
REQ-027 SHALL be a single module; no sub-module (comparator and counters are inline).

Verification
REQ-028 Reset low 10 cycles with toggling data_in -> all outputs 0, state UNLOCKED.
REQ-029 3 random bits, then BC x4, then 8'hAD, 8'hFE -> active rises on 4th BC's last-bit edge; valid_out pulses with data_out=8'hAD then 8'hFE, 8 cycles apart.
REQ-030 BC x2, then 8'h12, then BC x4, 8'h55 -> return to UNLOCKED after 8'h12, no valid; active after later 4 BCs; data_out=8'h55.
REQ-031 Active link, stream 8'h01, BC, 8'h02 -> default build: two pulses (01, 02), data_out held at 01 during BC; RX_COMMA_PASS_EN build: three pulses 01, BC, 02.
REQ-032 Active link, reset driven low at bit 4 of a byte, released, stream BC x4, 8'hFA -> active drops immediately, relocks, first valid byte 8'hFA.
REQ-033 Stream 8'h5E,8'hBC... with comma split across byte boundary of random data -> lock occurs only on bit-exact 8'hBC pattern and subsequent bytes align to it.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY definitions: default comma symbol, lock depth and receiver state encoding.
package phy_pkg;

   localparam logic [7:0] COMMA_DEFAULT  = 8'hBC;
   localparam int         N_LOCK_DEFAULT = 4;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ALIGNING = 2'd1,
      ACTIVE   = 2'd2
   } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with comma-based byte alignment (MSB first).
// Optional macro RX_COMMA_PASS_EN: deliver comma bytes in ACTIVE as ordinary data.
module serial_paralelo_rx
   import phy_pkg::*;
#(
   parameter logic [7:0] COMMA  = COMMA_DEFAULT,
   parameter int         N_LOCK = N_LOCK_DEFAULT
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam int            CW       = $clog2(N_LOCK + 1);
   localparam logic [CW-1:0] LOCK_CNT = CW'(N_LOCK);

`ifdef RX_COMMA_PASS_EN
   localparam logic PASS_COMMA = 1'b1;
`else
   localparam logic PASS_COMMA = 1'b0;
`endif

   rx_state_t     state_reg, state_next;
   logic [7:0]    shift_reg;
   logic [7:0]    nxt;
   logic [2:0]    bit_cnt_reg, bit_cnt_next;
   logic [CW-1:0] comma_cnt_reg, comma_cnt_next;
   logic [CW-1:0] comma_inc;
   logic [7:0]    data_out_reg, data_out_next;
   logic          valid_reg, valid_next;
   logic          boundary;
   logic          is_comma;

   assign nxt       = {shift_reg[6:0], data_in};
   assign boundary  = (bit_cnt_reg == 3'd7);
   assign is_comma  = (nxt == COMMA);
   assign comma_inc = comma_cnt_reg + 1'b1;

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_reg <= UNLOCKED;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         shift_reg     <= 8'h00;
         bit_cnt_reg   <= 3'd0;
         comma_cnt_reg <= '0;
         data_out_reg  <= 8'h00;
         valid_reg     <= 1'b0;
      end else begin
         shift_reg     <= nxt;
         bit_cnt_reg   <= bit_cnt_next;
         comma_cnt_reg <= comma_cnt_next;
         data_out_reg  <= data_out_next;
         valid_reg     <= valid_next;
      end
   end

   // UNLOCKED hunts bit by bit; once a comma is seen the byte phase is fixed
   // and only boundary edges are evaluated from then on.
   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      comma_cnt_next = comma_cnt_reg;
      data_out_next  = data_out_reg;
      valid_next     = 1'b0;
      case (state_reg)
         UNLOCKED: begin
            bit_cnt_next = 3'd0;
            if (is_comma) begin
               state_next     = ALIGNING;
               comma_cnt_next = CW'(1);
            end
         end
         ALIGNING: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_next = comma_inc;
                  if (comma_inc == LOCK_CNT) begin
                     state_next = ACTIVE;
                  end
               end else begin
                  state_next     = UNLOCKED;
                  comma_cnt_next = '0;
               end
            end
         end
         ACTIVE: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (boundary && (!is_comma || PASS_COMMA)) begin
               data_out_next = nxt;
               valid_next    = 1'b1;
            end
         end
         default: begin
            state_next     = UNLOCKED;
            bit_cnt_next   = 3'd0;
            comma_cnt_next = '0;
         end
      endcase
   end

   assign data_out  = data_out_reg;
   assign valid_out = valid_reg;
   assign active    = (state_reg == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed, table-driven bench for serial_paralelo_rx (comma expectations follow RX_COMMA_PASS_EN).
`timescale 1ns/1ps
module tb_serial_paralelo_rx;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   int checks     = 0;
   int errors     = 0;
   int pulses     = 0;
   int exp_pulses = 0;

   typedef struct {
      logic [7:0] din;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_active;
   } vec_t;

   vec_t vecs[$];

   serial_paralelo_rx dut (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every strobe must fall inside ACTIVE; also counted against the table total.
   always @(posedge clk_32f) begin
      #1;
      if (valid_out === 1'b1) begin
         pulses++;
         check("valid_outside_active", {31'd0, active}, 32'd1);
      end
   end

   function automatic void add(input logic [7:0] din, input logic v,
                               input logic [7:0] d, input logic a);
      vec_t r;
      r.din        = din;
      r.exp_valid  = v;
      r.exp_data   = d;
      r.exp_active = a;
      vecs.push_back(r);
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_vec(input int i);
      logic [7:0] b;
      logic       act0;
      int         bad_v;
      int         bad_a;
      b     = vecs[i].din;
      act0  = active;
      bad_v = 0;
      bad_a = 0;
      for (int k = 7; k >= 0; k--) begin
         send_bit(b[k]);
         if (k != 0) begin
            if (valid_out !== 1'b0) bad_v++;
            if (active !== act0) bad_a++;
         end
      end
      check($sformatf("row%0d_midbyte_valid", i), bad_v, 0);
      check($sformatf("row%0d_midbyte_active", i), bad_a, 0);
      check($sformatf("row%0d_valid", i), {31'd0, valid_out}, {31'd0, vecs[i].exp_valid});
      check($sformatf("row%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
      check($sformatf("row%0d_active", i), {31'd0, active}, {31'd0, vecs[i].exp_active});
      $display("row %0d din=%h valid=%b data=%h active=%b", i, b, valid_out, data_out, active);
   endtask

   task automatic hold_reset(input int n);
      int bad;
      bad = 0;
      @(negedge clk_32f);
      reset = 1'b0;
      #1;
      check("reset_immediate", {22'd0, active, valid_out, data_out}, 32'd0);
      for (int c = 0; c < n; c++) begin
         @(negedge clk_32f);
         data_in = ~data_in;
         @(posedge clk_32f);
         #1;
         if ((data_out !== 8'h00) || (valid_out !== 1'b0) || (active !== 1'b0)) bad++;
      end
      check("reset_hold_outputs", bad, 0);
      @(negedge clk_32f);
      data_in = 1'b0;
      reset   = 1'b1;
      $display("reset held %0d cycles, released", n);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 0..5: lock after four commas, then two data bytes
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b1);
      add(8'hAD, 1'b1, 8'hAD, 1'b1);
      add(8'hFE, 1'b1, 8'hFE, 1'b1);
      // 6..13: broken comma run falls back, later run locks
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'h12, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b1);
      add(8'h55, 1'b1, 8'h55, 1'b1);
      // 14..16: comma inside an active stream
      add(8'h01, 1'b1, 8'h01, 1'b1);
`ifdef RX_COMMA_PASS_EN
      add(8'hBC, 1'b1, 8'hBC, 1'b1);
`else
      add(8'hBC, 1'b0, 8'h01, 1'b1);
`endif
      add(8'h02, 1'b1, 8'h02, 1'b1);
      // 17..21: relock after a mid-byte reset
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b1);
      add(8'hFA, 1'b1, 8'hFA, 1'b1);
      // 22..28: near-miss patterns, lock only on the exact comma
      add(8'h5E, 1'b0, 8'h00, 1'b0);
      add(8'hBD, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b0);
      add(8'hBC, 1'b0, 8'h00, 1'b1);
      add(8'h33, 1'b1, 8'h33, 1'b1);

      foreach (vecs[i]) if (vecs[i].exp_valid) exp_pulses++;

      hold_reset(10);

      repeat (3) send_bit(1'($urandom_range(0, 1)));
      for (int i = 0; i <= 5; i++) send_vec(i);

      hold_reset(3);
      for (int i = 6; i <= 13; i++) send_vec(i);
      for (int i = 14; i <= 16; i++) send_vec(i);

      // Reset lands after the fourth bit of a byte
      check("pre_reset_active", {31'd0, active}, 32'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      hold_reset(3);
      for (int i = 17; i <= 21; i++) send_vec(i);

      hold_reset(3);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 22; i <= 28; i++) send_vec(i);

      repeat (3) @(negedge clk_32f);
      check("total_valid_pulses", pulses, exp_pulses);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
